// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pkg
// Description : Shared widths and encodings for the execute stage and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_stage_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 3;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b101;
    localparam logic [2:0] C_ALU_SLL = 3'b110;
    localparam logic [2:0] C_ALU_SRL = 3'b111;

    localparam logic [1:0] C_FWD_NONE      = 2'b00;
    localparam logic [1:0] C_FWD_RESULTW   = 2'b01;
    localparam logic [1:0] C_FWD_ALURESULT = 2'b10;

    localparam logic [1:0] C_RES_ALU   = 2'b00;
    localparam logic [1:0] C_RES_MEM   = 2'b01;
    localparam logic [1:0] C_RES_PCP4  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 8-bit combinational ALU with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import execute_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_ctrl,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            C_ALU_ADD: o_result = i_a + i_b;
            C_ALU_SUB: o_result = i_a - i_b;
            C_ALU_AND: o_result = i_a & i_b;
            C_ALU_OR:  o_result = i_a | i_b;
            C_ALU_XOR: o_result = i_a ^ i_b;
            C_ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            // Only the low three bits of B form the shift amount.
            C_ALU_SLL: o_result = i_a << i_b[2:0];
            C_ALU_SRL: o_result = i_a >> i_b[2:0];
            default:   o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : Pipeline EX stage: operand forwarding, ALU, branch resolve, EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [1:0]        ResultSrcE,
    input  logic [DATA_W-1:0] rd1E,
    input  logic [DATA_W-1:0] rd2E,
    input  logic [DATA_W-1:0] immExtE,
    input  logic [DATA_W-1:0] pcE,
    input  logic [DATA_W-1:0] pcPlus4E,
    input  logic [REG_W-1:0]  RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] pcPlus4M,
    output logic [REG_W-1:0]  RdM
);

    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_write_data;
    logic [DATA_W-1:0] w_src_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_zero;

    logic              reg_write_d,   reg_write_q;
    logic              mem_write_d,   mem_write_q;
    logic [1:0]        result_src_d,  result_src_q;
    logic [DATA_W-1:0] alu_result_d,  alu_result_q;
    logic [DATA_W-1:0] write_data_d,  write_data_q;
    logic [DATA_W-1:0] pc_plus4_d,    pc_plus4_q;
    logic [REG_W-1:0]  rd_d,          rd_q;

    // The 10 select feeds back the registered result of the previous instruction.
    always_comb begin
        w_src_a = rd1E;
        case (ForwardAE)
            C_FWD_RESULTW:   w_src_a = ResultW;
            C_FWD_ALURESULT: w_src_a = alu_result_q;
            default:         w_src_a = rd1E;
        endcase
    end

    always_comb begin
        w_write_data = rd2E;
        case (ForwardBE)
            C_FWD_RESULTW:   w_write_data = ResultW;
            C_FWD_ALURESULT: w_write_data = alu_result_q;
            default:         w_write_data = rd2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? immExtE : w_write_data;

    alu u_alu (
        .i_a      (w_src_a),
        .i_b      (w_src_b),
        .i_ctrl   (ALUControlE),
        .o_result (w_alu_result),
        .o_zero   (w_zero)
    );

    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = pcE + immExtE;

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        alu_result_d = w_alu_result;
        write_data_d = w_write_data;
        pc_plus4_d   = pcPlus4E;
        rd_d         = RdE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign pcPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;

endmodule
`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 RegWriteE, MemWriteE, BranchE, ALUSrcE  in  1 each  E-stage control bits from the decode/execute register.
REQ-004 ALUControlE  in  3  ALU operation select.
REQ-005 ResultSrcE  in  2  writeback source select, passed through to M.
REQ-006 rd1E, rd2E  in  8  register operands.
REQ-007 immExtE, pcE, pcPlus4E  in  8 each  immediate, instruction PC, PC+4.
REQ-008 RdE  in  3  destination register.
REQ-009 ForwardAE, ForwardBE  in  2 each  operand forwarding selects from the hazard unit.
REQ-010 ResultW  in  8  writeback-stage result for forwarding.
REQ-011 PCSrcE  out  1  branch taken, combinational.
REQ-012 PCTargetE  out  8  branch target, combinational.
REQ-013 RegWriteM, MemWriteM  out  1 each  registered control.
REQ-014 ResultSrcM  out  2  registered.
REQ-015 ALUResultM, WriteDataM, pcPlus4M  out  8 each  registered.
REQ-016 RdM  out  3  registered.

Function
REQ-017 SrcAE: ForwardAE 00 -> rd1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> rd1E.
REQ-018 WriteDataE: same ForwardBE mapping applied to rd2E.
REQ-019 SrcBE = immExtE when ALUSrcE=1, else WriteDataE.
REQ-020 ALU ops, 8-bit, results modulo 256:
- 000 add
- 001 sub
- 010 and
- 011 or
- 100 xor
- 101 slt, signed, result 1 or 0
- 110 sll by SrcBE[2:0]
- 111 srl by SrcBE[2:0]
REQ-021 ZeroE = 1 when the ALU result is 8'h00.
REQ-022 PCSrcE = BranchE AND ZeroE, purely combinational, same cycle.
REQ-023 PCTargetE = pcE + immExtE modulo 256; carry discarded.
REQ-024 EX/MEM register, latency 1 cycle, captured on every rising edge when rst=0:
- RegWriteM, MemWriteM, ResultSrcM, RdM, pcPlus4M take their E-stage counterparts.
- ALUResultM takes the ALU result.
- WriteDataM takes WriteDataE (forwarded, not rd2E).
REQ-025 The ForwardAE/BE=10 path uses the current registered ALUResultM (the previous instruction's result), never the same-cycle ALU output.
REQ-026 No stall or clear input; bubbles arrive as all-zero E-stage inputs and propagate as zero M-stage outputs.
REQ-027 PCSrcE and PCTargetE do not depend on rst.

Reset
REQ-028 When rst=1 at a rising edge, all M-stage outputs become 0, overriding capture.
REQ-029 Reset mid-stream discards the in-flight E-stage instruction; normal capture resumes on the first edge with rst=0.

Structure
REQ-030 Shared package holds:
- data width 8 and register-address width 3;
- ALU opcode constants (REQ-020);
- forward-select constants 00/01/10;
- ResultSrc encodings.
REQ-031 One sub-module, alu, provides the combinational result and zero flag; muxes and the EX/MEM register stay in execute_stage.

Verification
REQ-032 Add: rd1E=8'h05, rd2E=8'h03, ALUControlE=000, forwards 00, ALUSrcE=0 -> ALUResultM=8'h08 one edge later; WriteDataM=8'h03.
REQ-033 Signed slt: SrcA=8'hFF, SrcB=8'h01, ALUControlE=101 -> ALUResultM=8'h01. Unsigned overflow: 8'hF0+8'h20 -> 8'h10.
REQ-034 Branch: BranchE=1, rd1E=rd2E=8'h2A, ALUControlE=001, pcE=8'h10, immExtE=8'hF8 -> PCSrcE=1 and PCTargetE=8'h08 in the same cycle. With rd2E=8'h2B -> PCSrcE=0.
REQ-035 Back-to-back forwarding:
- cycle n: add producing ALUResultM=8'h08;
- cycle n+1: ForwardAE=10, immExtE=8'h01, ALUSrcE=1, add -> ALUResultM=8'h09;
- repeat with ForwardBE=01, ResultW=8'h77, MemWriteE=1 -> WriteDataM=8'h77.
REQ-036 Reset: outputs nonzero, assert rst for one edge -> all M-stage outputs 0 after that edge. The next edge with rst=0 captures the current E-stage inputs.
REQ-037 Shift ops: SrcA=8'h81, SrcB=8'h09 (amount 1) -> sll gives 8'h02, srl gives 8'h40.
